// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer: snapshots NBINS complex FFT bins on start, computes each
// bin's |X|^2 with one shared squarer, scales/saturates to 8 bits and streams
// the bytes over a valid/ready handshake with first/last markers.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   ena              global enable (low freezes all state)
//   start            frame request, honoured only in IDLE
//   bin_re, bin_im   packed signed bins, bin k at [k*IN_W +: IN_W]
//   out_data/valid/ready/first/last   byte stream
//   busy, done       status (done pulses one cycle at frame end)
module fft_bin_streamer #(
    parameter int NBINS = 8,
    parameter int IN_W  = 9,
    parameter int SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic [NBINS*IN_W-1:0] bin_re,
    input  logic [NBINS*IN_W-1:0] bin_im,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NBINS > 1) ? $clog2(NBINS) : 1;
    // square of a signed IN_W value needs 2*IN_W-1 bits; sum of two needs 2*IN_W
    localparam int ACC_W = 2 * IN_W - 1;
    localparam int SUM_W = 2 * IN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_RE,
        S_SQ_IM,
        S_SEND,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IDX_W-1:0]        r_idx;
    logic [ACC_W-1:0]        r_acc;
    logic signed [IN_W-1:0]  r_re [NBINS];
    logic signed [IN_W-1:0]  r_im [NBINS];
    logic [7:0]              r_data;
    logic                    r_valid;
    logic                    r_first;
    logic                    r_last;

    logic signed [IN_W-1:0]  w_op;
    logic signed [SUM_W-1:0] w_prod;
    logic [ACC_W-1:0]        w_sq;
    logic [SUM_W-1:0]        w_sum;
    logic [SUM_W-1:0]        w_scaled;
    logic [7:0]              w_sat;
    logic                    w_xfer;
    logic                    w_last;

    // Single squarer: operand is the real part in SQ_RE, imaginary otherwise.
    assign w_op     = (r_state == S_SQ_IM) ? r_im[r_idx] : r_re[r_idx];
    assign w_prod   = w_op * w_op;
    assign w_sq     = w_prod[ACC_W-1:0];
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_sq};
    assign w_scaled = w_sum >> SHIFT;
    assign w_sat    = (|w_scaled[SUM_W-1:8]) ? 8'hFF : w_scaled[7:0];

    assign w_xfer = r_valid & out_ready;
    assign w_last = (r_idx == LAST_IDX);

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_SQ_RE;
            S_SQ_RE: w_next = S_SQ_IM;
            S_SQ_IM: w_next = S_SEND;
            S_SEND:  if (w_xfer) w_next = w_last ? S_DONE : S_SQ_RE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            for (int k = 0; k < NBINS; k++) begin
                r_re[k] <= '0;
                r_im[k] <= '0;
            end
        end else if (ena) begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                        for (int k = 0; k < NBINS; k++) begin
                            r_re[k] <= bin_re[k*IN_W +: IN_W];
                            r_im[k] <= bin_im[k*IN_W +: IN_W];
                        end
                    end
                end
                S_SQ_RE: begin
                    r_acc <= w_sq;
                end
                S_SQ_IM: begin
                    r_data  <= w_sat;
                    r_first <= (r_idx == '0);
                    r_last  <= w_last;
                    r_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        if (!w_last) r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bin_streamer.sv
// tb_fft_bin_streamer: directed self-checking bench for fft_bin_streamer.
// Covers reset, zero frame, scaling/saturation, backpressure, snapshot, ena, abort.
module tb_fft_bin_streamer;

    localparam int NB = 8;
    localparam int W  = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b1;
    logic            start = 1'b0;
    logic            out_ready = 1'b1;
    logic [NB*W-1:0] bin_re = '0;
    logic [NB*W-1:0] bin_im = '0;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_first;
    logic            out_last;
    logic            busy;
    logic            done;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] got[$];
    logic [7:0] fmask;
    logic [7:0] lmask;
    int         dones;
    int         first_lat;
    int         hs_cyc;
    int         done_cyc;
    int         fcyc;

    logic [7:0] exp_zero [8];
    logic [7:0] exp_pat  [8];

    fft_bin_streamer #(.NBINS(NB), .IN_W(W), .SHIFT(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .start(start),
        .bin_re(bin_re),
        .bin_im(bin_im),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_first(out_first),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_bin(input int k, input int re, input int im);
        bin_re[k*W +: W] = W'(re);
        bin_im[k*W +: W] = W'(im);
    endtask

    task automatic load_pattern();
        for (int k = 0; k < NB; k++) set_bin(k, 0, 0);
        set_bin(0, 16, 0);
        set_bin(1, 100, -60);
        set_bin(2, -256, 0);
        set_bin(3, 255, 255);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] e [8]);
        check({tag, "_count"}, got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], e[i]);
        check({tag, "_first_mask"}, fmask, 8'h01);
        check({tag, "_last_mask"}, lmask, 8'h80);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_done_after_last"}, done_cyc, hs_cyc + 1);
        check({tag, "_latency"}, first_lat, 2);
        check({tag, "_idle_after"}, {31'd0, busy}, 0);
    endtask

    // Runs one frame from a start pulse. Knobs (-1 = off):
    // stall_bin: hold out_ready low 5 cycles when that bin is offered
    // ena_at:    drop ena for 3 cycles at that cycle
    // mid_at:    change inputs and pulse start again at that cycle
    task automatic run_frame(input int stall_bin, input int ena_at,
                             input int mid_at);
        logic [12:0] snap;
        logic [7:0]  sdata;
        got.delete();
        fmask = '0;
        lmask = '0;
        dones = 0;
        first_lat = -1;
        hs_cyc = -1;
        done_cyc = -1;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fcyc = 0;
        while (fcyc < 200 && !(dones > 0 && !busy)) begin
            if (fcyc == mid_at) begin
                for (int k = 0; k < NB; k++) set_bin(k, 100, 100);
                start = 1'b1;
            end
            if (fcyc == mid_at + 1) start = 1'b0;
            if (fcyc == ena_at) begin
                snap = {out_data, out_valid, out_first, out_last, busy, done};
                ena = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    check($sformatf("ena_freeze%0d", j),
                          {out_data, out_valid, out_first, out_last, busy, done},
                          snap);
                end
                ena = 1'b1;
            end
            if (out_valid && first_lat < 0) first_lat = fcyc;
            if (out_valid && got.size() == stall_bin) begin
                out_ready = 1'b0;
                sdata = out_data;
                for (int j = 0; j < 5; j++) begin
                    @(posedge clk); #1;
                    check($sformatf("stall_valid%0d", j), {31'd0, out_valid}, 1);
                    check($sformatf("stall_data%0d", j), out_data, sdata);
                end
                out_ready = 1'b1;
                stall_bin = -1;
            end
            if (out_valid && out_ready) begin
                if (got.size() < 8) begin
                    fmask[got.size()] = out_first;
                    lmask[got.size()] = out_last;
                end
                got.push_back(out_data);
                hs_cyc = fcyc;
            end
            if (done) begin
                dones++;
                done_cyc = fcyc;
            end
            @(posedge clk); #1;
            fcyc++;
        end
        start = 1'b0;
        check("frame_no_timeout", {31'd0, fcyc < 200}, 1);
    endtask

    initial begin
        int hs;
        int cyc;
        int dcount;
        exp_zero = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_pat  = '{8'd1, 8'd53, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_data", out_data, 0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_first", {31'd0, out_first}, 0);
        check("rst_last", {31'd0, out_last}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", {31'd0, busy}, 0);

        // all-zero bins
        run_frame(-1, -1, -1);
        check_stream("zero", exp_zero);

        // scaling and saturation
        load_pattern();
        run_frame(-1, -1, -1);
        check_stream("pat", exp_pat);

        // backpressure on bin 2
        run_frame(2, -1, -1);
        check_stream("stall", exp_pat);

        // snapshot isolation, second start ignored
        run_frame(-1, -1, 4);
        check_stream("snap", exp_pat);
        repeat (4) @(posedge clk);
        #1;
        check("snap_no_requeue", {31'd0, busy}, 0);

        // ena freeze during a valid byte
        load_pattern();
        run_frame(-1, 5, -1);
        check_stream("ena", exp_pat);

        // async reset during SEND of bin 4
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        hs = 0;
        while (cyc < 100 && !(out_valid && hs == 4)) begin
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reach_bin4", hs, 4);
        check("abort_in_send", {31'd0, out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_data", out_data, 0);
        check("abort_done", {31'd0, done}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcount = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (done || busy || out_valid) dcount++;
        end
        check("abort_no_resume", dcount, 0);
        run_frame(-1, -1, -1);
        check_stream("after_abort", exp_pat);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
